// File: rtl/iss_pkg.sv
// rtl/iss_pkg.sv - shared entry type and arbitration constants for the issue scheduler
package iss_pkg;

  localparam int ISS_PAYLOAD_W = 137;
  localparam int ISS_TAG_W     = 6;

  localparam logic RR_IQ  = 1'b0;
  localparam logic RR_LSQ = 1'b1;

  typedef struct packed {
    logic [ISS_PAYLOAD_W-1:0] payload;
    logic [ISS_TAG_W-1:0]     src1;
    logic                     src1rdy;
    logic [ISS_TAG_W-1:0]     src2;
    logic                     src2rdy;
    logic [ISS_TAG_W-1:0]     dest;
    logic                     needDest;
  } iq_entry_t;

endpackage

// File: rtl/iss_oldest_pick.sv
// rtl/iss_oldest_pick.sv - priority encoder returning the lowest-index (oldest) ready entry
module iss_oldest_pick #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     ready,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/iss_sched_param.sv
// rtl/iss_sched_param.sv - unified issue stage: collapsing IQ, in-order LSQ, busy table, RR select
module iss_sched_param
  import iss_pkg::*;
#(
  parameter int PAYLOAD_W = ISS_PAYLOAD_W,
  parameter int TAG_W     = ISS_TAG_W,
  parameter int NUM_PREG  = 64,
  parameter int IQ_DEPTH  = 16,
  parameter int LSQ_DEPTH = 16,
  parameter int WB_PORTS  = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          FREEZE,
  input  logic                          FLUSH,
  input  logic                          IQ_pushReq_IN,
  input  logic                          LSQ_pushReq_IN,
  input  logic [PAYLOAD_W-1:0]          push_payload_IN,
  input  logic [TAG_W-1:0]              push_src1_IN,
  input  logic [TAG_W-1:0]              push_src2_IN,
  input  logic                          push_imm_IN,
  input  logic [TAG_W-1:0]              push_dest_IN,
  input  logic                          push_needDest_IN,
  input  logic [WB_PORTS-1:0]           WB_valid_IN,
  input  logic [WB_PORTS*TAG_W-1:0]     WB_tag_IN,
  output logic [PAYLOAD_W-1:0]          IQLSQ_popData_OUT,
  output logic                          Valid_Instruction,
  output logic                          Mem_Instruction,
  output logic                          IQ_full_OUT,
  output logic                          LSQ_full_OUT,
  output logic [$clog2(IQ_DEPTH):0]     IQ_count_OUT,
  output logic [$clog2(LSQ_DEPTH):0]    LSQ_count_OUT
);

  localparam int IQ_IDX_W  = $clog2(IQ_DEPTH);
  localparam int IQ_CNT_W  = IQ_IDX_W + 1;
  localparam int LSQ_PTR_W = $clog2(LSQ_DEPTH);
  localparam int LSQ_CNT_W = LSQ_PTR_W + 1;

  logic [NUM_PREG-1:0]  busy, busyNext;
  iq_entry_t            iq     [IQ_DEPTH];
  iq_entry_t            iqNext [IQ_DEPTH];
  iq_entry_t            lsq    [LSQ_DEPTH];
  iq_entry_t            newEntry;
  logic [IQ_CNT_W-1:0]  iqCount;
  logic [LSQ_CNT_W-1:0] lsqCount;
  logic [LSQ_PTR_W-1:0] lsqHead, lsqTail;
  logic                 rrPtr;

  logic [IQ_DEPTH-1:0]  iqRdy;
  logic                 iqFound, lsqRdy;
  logic [IQ_IDX_W-1:0]  iqPickIdx;
  logic                 grantIq, grantLsq;
  logic                 iqFull, lsqFull, iqPush, lsqPush;
  logic [IQ_CNT_W-1:0]  iqSlot;

  function automatic logic wbHit(input logic [TAG_W-1:0] tag,
                                 input logic [WB_PORTS-1:0] vld,
                                 input logic [WB_PORTS*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++)
      if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  function automatic iq_entry_t wake(input iq_entry_t e,
                                     input logic [WB_PORTS-1:0] vld,
                                     input logic [WB_PORTS*TAG_W-1:0] tags);
    iq_entry_t r;
    r = e;
    if (wbHit(e.src1, vld, tags)) r.src1rdy = 1'b1;
    if (wbHit(e.src2, vld, tags)) r.src2rdy = 1'b1;
    return r;
  endfunction

  assign iqFull  = (iqCount == IQ_CNT_W'(IQ_DEPTH));
  assign lsqFull = (lsqCount == LSQ_CNT_W'(LSQ_DEPTH));
  assign iqPush  = IQ_pushReq_IN && !iqFull && !FREEZE;
  assign lsqPush = LSQ_pushReq_IN && !IQ_pushReq_IN && !lsqFull && !FREEZE;

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++)
      iqRdy[i] = (IQ_CNT_W'(i) < iqCount) && iq[i].src1rdy && iq[i].src2rdy;
  end

  assign lsqRdy = (lsqCount != '0) && lsq[lsqHead].src1rdy && lsq[lsqHead].src2rdy;

  iss_oldest_pick #(.N(IQ_DEPTH), .IDX_W(IQ_IDX_W)) u_pick (
    .ready (iqRdy),
    .found (iqFound),
    .index (iqPickIdx)
  );

  always_comb begin
    grantIq  = 1'b0;
    grantLsq = 1'b0;
    if (!FREEZE) begin
      if (iqFound && lsqRdy) begin
        grantIq  = (rrPtr == RR_IQ);
        grantLsq = (rrPtr == RR_LSQ);
      end else begin
        grantIq  = iqFound;
        grantLsq = lsqRdy;
      end
    end
  end

  // Source readiness at push includes a same-cycle writeback bypass.
  always_comb begin
    newEntry          = '0;
    newEntry.payload  = push_payload_IN;
    newEntry.src1     = push_src1_IN;
    newEntry.src2     = push_src2_IN;
    newEntry.dest     = push_dest_IN;
    newEntry.needDest = push_needDest_IN;
    newEntry.src1rdy  = !busy[push_src1_IN] || wbHit(push_src1_IN, WB_valid_IN, WB_tag_IN);
    newEntry.src2rdy  = push_imm_IN || !busy[push_src2_IN] ||
                        wbHit(push_src2_IN, WB_valid_IN, WB_tag_IN);
  end

  always_comb begin
    busyNext = busy;
    for (int k = 0; k < WB_PORTS; k++)
      if (WB_valid_IN[k]) busyNext[WB_tag_IN[k*TAG_W +: TAG_W]] = 1'b0;
    if ((iqPush || lsqPush) && push_needDest_IN) busyNext[push_dest_IN] = 1'b1;
  end

  // Collapse entries above the granted slot; a push lands just past the survivors.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++)
      iqNext[i] = wake(iq[i], WB_valid_IN, WB_tag_IN);
    if (grantIq) begin
      for (int i = 0; i < IQ_DEPTH - 1; i++)
        if (IQ_IDX_W'(i) >= iqPickIdx) iqNext[i] = wake(iq[i+1], WB_valid_IN, WB_tag_IN);
    end
    iqSlot = grantIq ? iqCount - 1'b1 : iqCount;
    if (iqPush) iqNext[iqSlot[IQ_IDX_W-1:0]] = newEntry;
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < IQ_DEPTH; i++) iq[i] <= iqNext[i];
    for (int i = 0; i < LSQ_DEPTH; i++) lsq[i] <= wake(lsq[i], WB_valid_IN, WB_tag_IN);
    if (lsqPush) lsq[lsqTail] <= newEntry;
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      busy              <= '0;
      iqCount           <= '0;
      lsqCount          <= '0;
      lsqHead           <= '0;
      lsqTail           <= '0;
      rrPtr             <= RR_IQ;
      Valid_Instruction <= 1'b0;
      Mem_Instruction   <= 1'b0;
      IQLSQ_popData_OUT <= '0;
    end else begin
      busy     <= busyNext;
      iqCount  <= iqCount + IQ_CNT_W'(iqPush) - IQ_CNT_W'(grantIq);
      lsqCount <= lsqCount + LSQ_CNT_W'(lsqPush) - LSQ_CNT_W'(grantLsq);
      if (lsqPush)  lsqTail <= lsqTail + 1'b1;
      if (grantLsq) lsqHead <= lsqHead + 1'b1;
      if (!FREEZE) begin
        Valid_Instruction <= grantIq || grantLsq;
        if (grantIq) begin
          IQLSQ_popData_OUT <= iq[iqPickIdx].payload;
          Mem_Instruction   <= 1'b0;
        end else if (grantLsq) begin
          IQLSQ_popData_OUT <= lsq[lsqHead].payload;
          Mem_Instruction   <= 1'b1;
        end
        if (iqFound && lsqRdy) rrPtr <= ~rrPtr;
      end
    end
  end

  assign IQ_full_OUT   = iqFull;
  assign LSQ_full_OUT  = lsqFull;
  assign IQ_count_OUT  = iqCount;
  assign LSQ_count_OUT = lsqCount;

endmodule

// File: tb/tb_iss_sched_param.sv
// tb/tb_iss_sched_param.sv - directed vector bench for iss_sched_param
module tb_iss_sched_param;

  localparam int PW = 137;
  localparam int TW = 6;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1, FREEZE = 1'b0, FLUSH = 1'b0;
  logic            iqPush = 1'b0, lsqPush = 1'b0;
  logic [PW-1:0]   payload = '0;
  logic [TW-1:0]   src1 = '0, src2 = '0, dest = '0;
  logic            imm = 1'b0, needDest = 1'b0;
  logic [1:0]      wbValid = '0;
  logic [2*TW-1:0] wbTag = '0;
  logic [PW-1:0]   popData;
  logic            validInstr, memInstr, iqFull, lsqFull;
  logic [4:0]      iqCount, lsqCount;

  int nTests = 0;
  int nFail  = 0;

  always #5 CLK = ~CLK;

  iss_sched_param dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .FREEZE            (FREEZE),
    .FLUSH             (FLUSH),
    .IQ_pushReq_IN     (iqPush),
    .LSQ_pushReq_IN    (lsqPush),
    .push_payload_IN   (payload),
    .push_src1_IN      (src1),
    .push_src2_IN      (src2),
    .push_imm_IN       (imm),
    .push_dest_IN      (dest),
    .push_needDest_IN  (needDest),
    .WB_valid_IN       (wbValid),
    .WB_tag_IN         (wbTag),
    .IQLSQ_popData_OUT (popData),
    .Valid_Instruction (validInstr),
    .Mem_Instruction   (memInstr),
    .IQ_full_OUT       (iqFull),
    .LSQ_full_OUT      (lsqFull),
    .IQ_count_OUT      (iqCount),
    .LSQ_count_OUT     (lsqCount)
  );

  typedef struct {
    logic       rst, frz, fl, iqP, lsqP;
    int         pay;
    logic [5:0] s1, s2;
    logic       im;
    logic [5:0] dst;
    logic       nd;
    logic [1:0] wbV;
    logic [5:0] wb0, wb1;
    logic       eV, eM;
    int         ePay, eIq, eLsq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic frz, logic fl, logic iqP, logic lsqP, int pay,
                              logic [5:0] s1, logic [5:0] s2, logic im, logic [5:0] dst,
                              logic nd, logic [1:0] wbV, logic [5:0] wb0, logic [5:0] wb1,
                              logic eV, logic eM, int ePay, int eIq, int eLsq);
    vec_t v;
    v.rst = rst; v.frz = frz; v.fl = fl; v.iqP = iqP; v.lsqP = lsqP; v.pay = pay;
    v.s1 = s1; v.s2 = s2; v.im = im; v.dst = dst; v.nd = nd;
    v.wbV = wbV; v.wb0 = wb0; v.wb1 = wb1;
    v.eV = eV; v.eM = eM; v.ePay = ePay; v.eIq = eIq; v.eLsq = eLsq;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [255:0] act,
                     input logic [255:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int step);
    @(negedge CLK);
    RESET = v.rst; FREEZE = v.frz; FLUSH = v.fl;
    iqPush = v.iqP; lsqPush = v.lsqP; payload = PW'(v.pay);
    src1 = v.s1; src2 = v.s2; imm = v.im; dest = v.dst; needDest = v.nd;
    wbValid = v.wbV; wbTag = {v.wb1, v.wb0};
    @(posedge CLK);
    #1;
    chk("valid", step, 256'(validInstr), 256'(v.eV));
    chk("payload", step, 256'(popData), 256'(v.ePay));
    chk("iq_count", step, 256'(iqCount), 256'(v.eIq));
    chk("lsq_count", step, 256'(lsqCount), 256'(v.eLsq));
    chk("iq_full", step, 256'(iqFull), 256'(v.eIq == 16));
    chk("lsq_full", step, 256'(lsqFull), 256'(v.eLsq == 16));
    if (v.eV || v.rst || v.fl) chk("mem", step, 256'(memInstr), 256'(v.eM));
  endtask

  // Shorthands: IQ push, LSQ push, idle cycle, writeback cycle.
  function automatic vec_t pIq(int pay, logic [5:0] s1, logic [5:0] s2, logic im,
                               logic [5:0] dst, logic nd, logic eV, logic eM, int ePay,
                               int eIq, int eLsq);
    return mk(0, 0, 0, 1, 0, pay, s1, s2, im, dst, nd, 2'b00, 0, 0, eV, eM, ePay, eIq, eLsq);
  endfunction

  function automatic vec_t pLsq(int pay, logic [5:0] s1, logic eV, logic eM, int ePay,
                                int eIq, int eLsq);
    return mk(0, 0, 0, 0, 1, pay, s1, 0, 1, 0, 0, 2'b00, 0, 0, eV, eM, ePay, eIq, eLsq);
  endfunction

  function automatic vec_t idle(logic eV, logic eM, int ePay, int eIq, int eLsq);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, eV, eM, ePay, eIq, eLsq);
  endfunction

  function automatic vec_t wb(logic [1:0] wbV, logic [5:0] t0, logic [5:0] t1, logic eV,
                              logic eM, int ePay, int eIq, int eLsq);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wbV, t0, t1, eV, eM, ePay, eIq, eLsq);
  endfunction

  initial begin
    int step;
    // Reset, simple issue, busy-until-writeback, oldest-ready select.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pIq(1, 1, 2, 0, 5, 1, 0, 0, 0, 1, 0));
    vecs.push_back(idle(1, 0, 1, 0, 0));
    vecs.push_back(pIq(2, 5, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(pIq(3, 1, 2, 0, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(idle(1, 0, 3, 1, 0));
    vecs.push_back(wb(2'b01, 5, 0, 0, 0, 3, 1, 0));
    vecs.push_back(idle(1, 0, 2, 0, 0));
    // Round-robin between IQ and LSQ once all four wake together.
    vecs.push_back(pIq(4, 1, 2, 0, 10, 1, 0, 0, 2, 1, 0));
    vecs.push_back(idle(1, 0, 4, 0, 0));
    vecs.push_back(pIq(11, 10, 0, 1, 0, 0, 0, 0, 4, 1, 0));
    vecs.push_back(pIq(12, 10, 0, 1, 0, 0, 0, 0, 4, 2, 0));
    vecs.push_back(pLsq(21, 10, 0, 0, 4, 2, 1));
    vecs.push_back(pLsq(22, 10, 0, 0, 4, 2, 2));
    vecs.push_back(wb(2'b01, 10, 0, 0, 0, 4, 2, 2));
    vecs.push_back(idle(1, 0, 11, 1, 2));
    vecs.push_back(idle(1, 1, 21, 1, 1));
    vecs.push_back(idle(1, 0, 12, 0, 1));
    vecs.push_back(idle(1, 1, 22, 0, 0));
    // Push bypass, then a set that collides with a wakeup on the same tag.
    vecs.push_back(pIq(29, 1, 2, 0, 9, 1, 0, 0, 22, 1, 0));
    vecs.push_back(idle(1, 0, 29, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 30, 9, 0, 1, 0, 0, 2'b01, 9, 0, 0, 0, 29, 1, 0));
    vecs.push_back(idle(1, 0, 30, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 31, 1, 2, 0, 7, 1, 2'b01, 7, 0, 0, 0, 30, 1, 0));
    vecs.push_back(pIq(32, 7, 0, 1, 0, 0, 1, 0, 31, 1, 0));
    vecs.push_back(idle(0, 0, 31, 1, 0));
    vecs.push_back(wb(2'b10, 0, 7, 0, 0, 31, 1, 0));
    vecs.push_back(idle(1, 0, 32, 0, 0));
    // FREEZE holds outputs but wakeup still lands; then FLUSH.
    vecs.push_back(pIq(39, 1, 2, 0, 12, 1, 0, 0, 32, 1, 0));
    vecs.push_back(pIq(40, 12, 0, 1, 0, 0, 1, 0, 39, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 45, 1, 2, 0, 0, 0, 2'b01, 12, 0, 1, 0, 39, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 39, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 39, 1, 0));
    vecs.push_back(idle(1, 0, 40, 0, 0));
    vecs.push_back(pIq(41, 1, 2, 0, 13, 1, 0, 0, 40, 1, 0));
    vecs.push_back(pLsq(42, 13, 1, 0, 41, 0, 1));
    vecs.push_back(pIq(43, 13, 0, 1, 0, 0, 0, 0, 41, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 46, 1, 2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(pIq(44, 13, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(idle(1, 0, 44, 0, 0));

    step = 0;
    foreach (vecs[i]) begin
      apply(vecs[i], step);
      step++;
    end

    // IQ fill to full, dropped pushes, push+pop at full, in-order drain.
    apply(pIq(100, 1, 2, 0, 20, 1, 0, 0, 44, 1, 0), step++);
    apply(idle(1, 0, 100, 0, 0), step++);
    for (int k = 0; k < 16; k++)
      apply(pIq(101 + k, 20, 0, 1, 0, 0, 0, 0, 100, k + 1, 0), step++);
    apply(pIq(199, 1, 2, 0, 0, 0, 0, 0, 100, 16, 0), step++);
    apply(wb(2'b01, 20, 0, 0, 0, 100, 16, 0), step++);
    apply(pIq(200, 1, 2, 0, 0, 0, 1, 0, 101, 15, 0), step++);
    for (int k = 0; k < 15; k++)
      apply(idle(1, 0, 102 + k, 14 - k, 0), step++);
    apply(idle(0, 0, 116, 0, 0), step++);

    // LSQ fill to full with pointer wrap, then in-order drain.
    apply(pIq(300, 1, 2, 0, 21, 1, 0, 0, 116, 1, 0), step++);
    apply(idle(1, 0, 300, 0, 0), step++);
    for (int k = 0; k < 16; k++)
      apply(pLsq(301 + k, 21, 0, 0, 300, 0, k + 1), step++);
    apply(pLsq(399, 1, 0, 0, 300, 0, 16), step++);
    apply(wb(2'b10, 0, 21, 0, 0, 300, 0, 16), step++);
    for (int k = 0; k < 16; k++)
      apply(idle(1, 1, 301 + k, 0, 15 - k), step++);

    // Both push requests high: IQ takes it, LSQ push dropped.
    apply(mk(0, 0, 0, 1, 1, 500, 1, 2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 316, 1, 0), step++);
    apply(idle(1, 0, 500, 0, 0), step++);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
